// File: rtl/decoder_hold_2to4_if.sv
// Handshake and output bundle for decoder_hold_2to4.
// master: the code producer and the observer of the decoded outputs.
// slave: the decoder itself.
interface decoder_hold_2to4_if;
    logic       en;
    logic       in_valid;
    logic [1:0] in_code;
    logic       in_ready;
    logic [3:0] y;
    logic       y_valid;
    logic       busy;
    logic       done;

    modport master (
        output en, in_valid, in_code,
        input  in_ready, y, y_valid, busy, done
    );

    modport slave (
        input  en, in_valid, in_code,
        output in_ready, y, y_valid, busy, done
    );
endinterface

// File: rtl/decoder_hold_2to4.sv
// Sequential 2-to-4 one-hot decoder with hold time and a one-entry pending buffer.
// A word is accepted over a valid/ready handshake. Its one-hot value is then held on y.
// A second word can wait in the pending slot, so consecutive words play out with no gap.
// Optional feature macro: DEC_STRETCH_EN.
//   Defined: each word is held for HOLD cycles.
//   Undefined: the counter is removed and each word lasts one cycle.
module decoder_hold_2to4 #(
    parameter int HOLD = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    decoder_hold_2to4_if.slave     bus
);

    if (HOLD < 1 || HOLD > 255) begin : g_bad_hold
        $error("decoder_hold_2to4: HOLD must be in 1..255");
    end

    typedef enum logic {
        S_IDLE = 1'b0,
        S_HOLD = 1'b1
    } state_t;

    state_t     state, state_n;
    logic [3:0] y_q, y_n;
    logic       yv_q, yv_n;
    logic       done_q, done_n;
    logic       pend_valid, pv_n;
    logic [1:0] pend_code, pc_n;
    logic       xfer;
    logic       cnt_zero;

    function automatic logic [3:0] decode(input logic [1:0] c);
        return 4'b0001 << c;
    endfunction

`ifdef DEC_STRETCH_EN
    localparam int CW = (HOLD > 1) ? $clog2(HOLD) : 1;
    localparam logic [CW-1:0] RELOAD = CW'(HOLD - 1);

    logic [CW-1:0] cnt, cnt_n;

    assign cnt_zero = (cnt == '0);

    // Hold counter register, cleared by reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt <= '0;
        else     cnt <= cnt_n;
    end
`else
    assign cnt_zero = 1'b1;
`endif

    assign xfer         = bus.in_valid && bus.in_ready;
    assign bus.in_ready = bus.en && !pend_valid;
    assign bus.y        = y_q;
    assign bus.y_valid  = yv_q;
    assign bus.done     = done_q;
    assign bus.busy     = (state == S_HOLD) || pend_valid;

    // State, output and pending-slot registers; reset forces the idle, empty condition
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            y_q        <= 4'b0000;
            yv_q       <= 1'b0;
            done_q     <= 1'b0;
            pend_valid <= 1'b0;
            pend_code  <= 2'b00;
        end else begin
            state      <= state_n;
            y_q        <= y_n;
            yv_q       <= yv_n;
            done_q     <= done_n;
            pend_valid <= pv_n;
            pend_code  <= pc_n;
        end
    end

    // Next-state logic. At the end of a word: pending first, then bypass, otherwise idle
    always_comb begin
        state_n = state;
        y_n     = y_q;
        yv_n    = yv_q;
        done_n  = 1'b0;
        pv_n    = pend_valid;
        pc_n    = pend_code;
`ifdef DEC_STRETCH_EN
        cnt_n   = cnt;
`endif
        if (!bus.en) begin
            state_n = S_IDLE;
            y_n     = 4'b0000;
            yv_n    = 1'b0;
            pv_n    = 1'b0;
`ifdef DEC_STRETCH_EN
            cnt_n   = '0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (xfer) begin
                        y_n     = decode(bus.in_code);
                        yv_n    = 1'b1;
                        state_n = S_HOLD;
`ifdef DEC_STRETCH_EN
                        cnt_n   = RELOAD;
`endif
                    end
                end
                S_HOLD: begin
                    if (!cnt_zero) begin
`ifdef DEC_STRETCH_EN
                        cnt_n = cnt - 1'b1;
`endif
                        if (xfer) begin
                            pv_n = 1'b1;
                            pc_n = bus.in_code;
                        end
                    end else begin
                        done_n = 1'b1;
                        if (pend_valid) begin
                            y_n  = decode(pend_code);
                            pv_n = 1'b0;
`ifdef DEC_STRETCH_EN
                            cnt_n = RELOAD;
`endif
                        end else if (xfer) begin
                            y_n = decode(bus.in_code);
`ifdef DEC_STRETCH_EN
                            cnt_n = RELOAD;
`endif
                        end else begin
                            y_n     = 4'b0000;
                            yv_n    = 1'b0;
                            state_n = S_IDLE;
                        end
                    end
                end
                default: begin
                    state_n = S_IDLE;
                    y_n     = 4'b0000;
                    yv_n    = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_decoder_hold_2to4.sv
// Testbench for decoder_hold_2to4.
// The reference model is a queue of accepted codes. The head of the queue is the word on y,
// and a second entry is the pending slot. The head's remaining display cycles are tracked.
// The effective hold time follows DEC_STRETCH_EN.
module tb_decoder_hold_2to4;

    localparam int HOLD_P = 4;
`ifdef DEC_STRETCH_EN
    localparam int H = HOLD_P;
`else
    localparam int H = 1;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;

    decoder_hold_2to4_if bus ();

    decoder_hold_2to4 #(.HOLD(HOLD_P)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    int q[$];
    int rem   = 0;
    bit mdone = 1'b0;

    task automatic checkOne(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic checkOutput();
        logic [3:0] ey;
        ey = (q.size() > 0) ? (4'b0001 << q[0]) : 4'b0000;
        checkOne("y",        bus.y,               ey);
        checkOne("y_valid",  {3'b0, bus.y_valid}, {3'b0, q.size() > 0});
        checkOne("busy",     {3'b0, bus.busy},    {3'b0, q.size() > 0});
        checkOne("done",     {3'b0, bus.done},    {3'b0, mdone});
        checkOne("in_ready", {3'b0, bus.in_ready},
                 {3'b0, (bus.en === 1'b1) && (q.size() < 2)});
    endtask

    task automatic modelReset();
        q.delete();
        rem   = 0;
        mdone = 1'b0;
    endtask

    // One clock edge of the reference model, using the inputs held across that edge
    task automatic modelStep(input bit e, input bit v, input int c);
        bit xfer;
        bit newHead;
        xfer    = e && v && (q.size() < 2);
        newHead = 1'b0;
        if (!e) begin
            modelReset();
        end else begin
            mdone = 1'b0;
            if (q.size() > 0) begin
                rem--;
                if (rem == 0) begin
                    mdone = 1'b1;
                    void'(q.pop_front());
                    newHead = 1'b1;
                end
            end else begin
                newHead = 1'b1;
            end
            if (xfer) q.push_back(c);
            if (newHead && q.size() > 0) rem = H;
        end
    endtask

    // Drive one cycle: set inputs at the falling edge, check, then advance the model at the rising edge
    task automatic applyStimulus(input bit e, input bit v, input int c);
        @(negedge clk);
        bus.en       = e;
        bus.in_valid = v;
        bus.in_code  = 2'(c);
        #1;
        checkOutput();
        @(posedge clk);
        modelStep(e, v, c);
    endtask

    initial begin
        bus.en       = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_code  = 2'b00;
        modelReset();

        // Reset state while reset is held
        #2;
        checkOutput();
        @(negedge clk);
        rst = 1'b0;
        #1;
        checkOutput();

        // Single word, code 2
        applyStimulus(1, 1, 2);
        repeat (H + 2) applyStimulus(1, 0, 0);

        // Back-to-back stream with in_valid held high
        applyStimulus(1, 1, 3);
        applyStimulus(1, 1, 0);
        repeat (H) applyStimulus(1, 1, 1);
        repeat (3 * H + 2) applyStimulus(1, 0, 0);

        // Bypass: second code shown only in the last cycle of the first word
        applyStimulus(1, 1, 1);
        repeat (H - 1) applyStimulus(1, 0, 0);
        applyStimulus(1, 1, 2);
        repeat (H + 2) applyStimulus(1, 0, 0);

        // Abort with the pending slot full, then hold en low
        applyStimulus(1, 1, 0);
        applyStimulus(1, 1, 3);
        applyStimulus(0, 1, 1);
        applyStimulus(0, 1, 2);
        applyStimulus(1, 0, 0);

        // Codes 0..3 back to back
        for (int i = 0; i < 4; i++) applyStimulus(1, 1, i);
        repeat (4 * H + 2) applyStimulus(1, 0, 0);

        // Asynchronous reset in the middle of a word showing 4'b0100
        applyStimulus(1, 1, 2);
        @(negedge clk);
        bus.in_valid = 1'b0;
        #1;
        checkOutput();
        @(posedge clk);
        modelStep(1, 0, 0);
        #2;
        rst = 1'b1;
        modelReset();
        #1;
        checkOne("rst_y",    bus.y,               4'b0000);
        checkOne("rst_yv",   {3'b0, bus.y_valid}, 4'b0000);
        checkOne("rst_busy", {3'b0, bus.busy},    4'b0000);
        checkOne("rst_done", {3'b0, bus.done},    4'b0000);
        @(negedge clk);
        rst = 1'b0;
        #1;
        checkOutput();

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            applyStimulus($urandom_range(0, 24) != 0,
                          $urandom_range(0, 2) != 0,
                          int'($urandom_range(0, 3)));
        end
        applyStimulus(1, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
